pc_sequencer: RTL and testbench

//  Next-generation fetch PC unit: holds the architectural fetch PC and sequences it through start-up,
//  run, stall, branch/trap redirect and halt. It replaces the plain enable-gated PC register at the

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bus: control requests in, fetch address and status out.
// master: the side driving trigger/stall/halt/trap/redirect (hazard unit, execute, bench).
// slave : the PC sequencer itself.
interface pc_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  trigger;
    logic                  stall;
    logic                  halt;
    logic                  trap_valid;
    logic [DATA_WIDTH-1:0] trap_pc;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic [DATA_WIDTH-1:0] pc_out;
    logic [DATA_WIDTH-1:0] pc_plus_inc;
    logic                  fetch_valid;
    logic                  flush;
    logic                  misalign_err;
    logic [1:0]            run_state;
    logic [CNT_WIDTH-1:0]  fetch_count;

    modport master (
        output trigger, stall, halt, trap_valid, trap_pc, redirect_valid, redirect_pc,
        input  pc_out, pc_plus_inc, fetch_valid, flush, misalign_err, run_state, fetch_count
    );

    modport slave (
        input  trigger, stall, halt, trap_valid, trap_pc, redirect_valid, redirect_pc,
        output pc_out, pc_plus_inc, fetch_valid, flush, misalign_err, run_state, fetch_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer. Holds the architectural fetch PC and moves it through
// start-up (WAIT_TRIG), RUN and HALTED, applying trap and branch redirects.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - pc_sequencer_if.slave: trigger/stall/halt/trap/redirect requests in;
//          pc_out, pc_plus_inc, fetch_valid, flush, misalign_err, run_state,
//          fetch_count out.
module pc_sequencer #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    PC_INC       = 4,
    parameter int                    ALIGN_BITS   = 2,
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        WAIT_TRIG = 2'b00,
        RUN       = 2'b01,
        HALTED    = 2'b10
    } state_e;

    // A mask rather than a part-select keeps ALIGN_BITS == 0 legal.
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [DATA_WIDTH-1:0] INC_V      = DATA_WIDTH'(PC_INC);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  misalign_q, misalign_d;
    logic [DATA_WIDTH-1:0] pc_plus_inc;
    logic                  misaligned;
    logic                  flush;

    always_comb begin
        pc_plus_inc = pc_q + INC_V;
        misaligned  = |(bus.redirect_pc & ALIGN_MASK);
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        misalign_d  = 1'b0;
        flush       = 1'b0;

        case (state_q)
            WAIT_TRIG: begin
                if (bus.trigger) state_d = RUN;
            end
            RUN: begin
                if (!bus.stall && !bus.halt && (count_q != '1))
                    count_d = count_q + CNT_WIDTH'(1);

                if (bus.trap_valid) begin
                    // Trap beats stall and halt; target is force-aligned.
                    pc_d  = bus.trap_pc & ~ALIGN_MASK;
                    flush = 1'b1;
                end else if (bus.redirect_valid && !misaligned) begin
                    pc_d  = bus.redirect_pc;
                    flush = 1'b1;
                    if (bus.halt) state_d = HALTED;
                end else begin
                    // A rejected misaligned redirect falls through to halt/stall/increment.
                    if (bus.redirect_valid) misalign_d = 1'b1;
                    if (bus.halt)
                        state_d = HALTED;
                    else if (!bus.stall)
                        pc_d = pc_plus_inc;
                end
            end
            HALTED: begin
                if (bus.trigger) state_d = RUN;
            end
            default: begin
                state_d = WAIT_TRIG;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WAIT_TRIG;
            pc_q       <= RESET_VECTOR;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_plus_inc  = pc_plus_inc;
    assign bus.fetch_valid  = (state_q == RUN);
    assign bus.flush        = flush;
    assign bus.misalign_err = misalign_q;
    assign bus.run_state    = state_q;
    assign bus.fetch_count  = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic clk;
    logic rst;
    logic rst8;
    int   n_checks;
    int   n_fail;

    pc_sequencer_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus ();
    pc_sequencer_if #(.DATA_WIDTH(8),  .CNT_WIDTH(3))  bus8 ();

    pc_sequencer #(
        .DATA_WIDTH(32), .RESET_VECTOR(32'h0), .PC_INC(4), .ALIGN_BITS(2), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    pc_sequencer #(
        .DATA_WIDTH(8), .RESET_VECTOR(8'h0), .PC_INC(4), .ALIGN_BITS(2), .CNT_WIDTH(3)
    ) dut8 (
        .clk(clk), .rst(rst8), .bus(bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.trigger = 0; bus.stall = 0; bus.halt = 0;
        bus.trap_valid = 0; bus.trap_pc = '0;
        bus.redirect_valid = 0; bus.redirect_pc = '0;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        bus.trap_valid = 1; bus.trap_pc = 32'h400;
        tick(); tick();
        n_checks++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.pc_out, 32'h0); end
        n_checks++; if (bus.run_state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want %b", bus.run_state, 2'b00); end
        n_checks++; if (bus.fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.fetch_count); end
        n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", bus.misalign_err); end
        rst = 1;
        // Trap and stall are ignored while waiting for trigger.
        bus.stall = 1;
        #1;
        n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL wait_flush: got %b want 0", bus.flush); end
        for (int i = 0; i < 5; i++) tick();
        clear_inputs();
        n_checks++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL wait_pc: got %h want %h", bus.pc_out, 32'h0); end
        n_checks++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL wait_fetch_valid: got %b want 0", bus.fetch_valid); end
        n_checks++; if (bus.run_state !== 2'b00) begin n_fail++; $display("FAIL wait_state: got %b want 00", bus.run_state); end
    endtask

    task automatic test_start();
        bus.trigger = 1;
        tick();
        bus.trigger = 0;
        n_checks++; if (bus.run_state !== 2'b01) begin n_fail++; $display("FAIL start_state: got %b want 01", bus.run_state); end
        n_checks++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL start_pc: got %h want 0", bus.pc_out); end
        n_checks++; if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL start_fetch_valid: got %b want 1", bus.fetch_valid); end
        n_checks++; if (bus.pc_plus_inc !== 32'h4) begin n_fail++; $display("FAIL start_pc_plus_inc: got %h want 4", bus.pc_plus_inc); end
        tick();
        n_checks++; if (bus.pc_out !== 32'h4) begin n_fail++; $display("FAIL seq_pc1: got %h want 4", bus.pc_out); end
        tick();
        n_checks++; if (bus.pc_out !== 32'h8) begin n_fail++; $display("FAIL seq_pc2: got %h want 8", bus.pc_out); end
        tick();
        n_checks++; if (bus.pc_out !== 32'hC) begin n_fail++; $display("FAIL seq_pc3: got %h want c", bus.pc_out); end
        n_checks++; if (bus.fetch_count !== 32'd3) begin n_fail++; $display("FAIL seq_count: got %0d want 3", bus.fetch_count); end
    endtask

    task automatic test_stall();
        tick();
        n_checks++; if (bus.pc_out !== 32'h10) begin n_fail++; $display("FAIL stall_pre_pc: got %h want 10", bus.pc_out); end
        bus.stall = 1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (bus.pc_out !== 32'h10) begin n_fail++; $display("FAIL stall_pc: got %h want 10", bus.pc_out); end
        n_checks++; if (bus.fetch_count !== 32'd4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", bus.fetch_count); end
        bus.stall = 0;
        tick();
        n_checks++; if (bus.pc_out !== 32'h14) begin n_fail++; $display("FAIL stall_release_pc: got %h want 14", bus.pc_out); end
        n_checks++; if (bus.fetch_count !== 32'd5) begin n_fail++; $display("FAIL stall_release_count: got %0d want 5", bus.fetch_count); end
    endtask

    task automatic test_redirect();
        tick(); tick(); tick();
        n_checks++; if (bus.pc_out !== 32'h20) begin n_fail++; $display("FAIL redir_pre_pc: got %h want 20", bus.pc_out); end
        bus.stall = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h100;
        #1;
        n_checks++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL redir_stall_flush: got %b want 1", bus.flush); end
        tick();
        n_checks++; if (bus.pc_out !== 32'h100) begin n_fail++; $display("FAIL redir_stall_pc: got %h want 100", bus.pc_out); end
        n_checks++; if (bus.fetch_count !== 32'd8) begin n_fail++; $display("FAIL redir_stall_count: got %0d want 8", bus.fetch_count); end
        bus.stall = 0; bus.redirect_pc = 32'h300;
        bus.trap_valid = 1; bus.trap_pc = 32'h200;
        #1;
        n_checks++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL trap_flush: got %b want 1", bus.flush); end
        tick();
        n_checks++; if (bus.pc_out !== 32'h200) begin n_fail++; $display("FAIL trap_prio_pc: got %h want 200", bus.pc_out); end
        bus.redirect_valid = 0; bus.trap_pc = 32'h203;
        tick();
        bus.trap_valid = 0;
        n_checks++; if (bus.pc_out !== 32'h200) begin n_fail++; $display("FAIL trap_align_pc: got %h want 200", bus.pc_out); end
        n_checks++; if (bus.fetch_count !== 32'd10) begin n_fail++; $display("FAIL trap_count: got %0d want 10", bus.fetch_count); end
    endtask

    task automatic test_misalign();
        bus.redirect_valid = 1; bus.redirect_pc = 32'h40;
        tick();
        n_checks++; if (bus.pc_out !== 32'h40) begin n_fail++; $display("FAIL mis_pre_pc: got %h want 40", bus.pc_out); end
        bus.redirect_pc = 32'h102;
        #1;
        n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL mis_flush: got %b want 0", bus.flush); end
        tick();
        bus.redirect_valid = 0;
        n_checks++; if (bus.pc_out !== 32'h44) begin n_fail++; $display("FAIL mis_pc: got %h want 44", bus.pc_out); end
        n_checks++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_err_set: got %b want 1", bus.misalign_err); end
        tick();
        n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_err_clear: got %b want 0", bus.misalign_err); end
        n_checks++; if (bus.pc_out !== 32'h48) begin n_fail++; $display("FAIL mis_next_pc: got %h want 48", bus.pc_out); end
    endtask

    task automatic test_halt();
        bus.redirect_valid = 1; bus.redirect_pc = 32'h50;
        tick();
        bus.redirect_valid = 0;
        bus.halt = 1;
        tick();
        bus.halt = 0;
        n_checks++; if (bus.run_state !== 2'b10) begin n_fail++; $display("FAIL halt_state: got %b want 10", bus.run_state); end
        n_checks++; if (bus.pc_out !== 32'h50) begin n_fail++; $display("FAIL halt_pc: got %h want 50", bus.pc_out); end
        n_checks++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_fetch_valid: got %b want 0", bus.fetch_valid); end
        bus.redirect_valid = 1; bus.redirect_pc = 32'h300;
        #1;
        n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL halt_redir_flush: got %b want 0", bus.flush); end
        tick();
        bus.redirect_valid = 0;
        n_checks++; if (bus.pc_out !== 32'h50) begin n_fail++; $display("FAIL halt_redir_pc: got %h want 50", bus.pc_out); end
        bus.trigger = 1; bus.halt = 1;
        tick();
        bus.trigger = 0; bus.halt = 0;
        n_checks++; if (bus.run_state !== 2'b01) begin n_fail++; $display("FAIL resume_state: got %b want 01", bus.run_state); end
        tick();
        n_checks++; if (bus.pc_out !== 32'h54) begin n_fail++; $display("FAIL resume_pc: got %h want 54", bus.pc_out); end
        // Aligned redirect together with halt: redirect taken, then halted.
        bus.redirect_valid = 1; bus.redirect_pc = 32'h60; bus.halt = 1;
        #1;
        n_checks++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL redir_halt_flush: got %b want 1", bus.flush); end
        tick();
        clear_inputs();
        n_checks++; if (bus.pc_out !== 32'h60) begin n_fail++; $display("FAIL redir_halt_pc: got %h want 60", bus.pc_out); end
        n_checks++; if (bus.run_state !== 2'b10) begin n_fail++; $display("FAIL redir_halt_state: got %b want 10", bus.run_state); end
    endtask

    task automatic test_narrow();
        bus8.trigger = 0; bus8.stall = 0; bus8.halt = 0;
        bus8.trap_valid = 0; bus8.trap_pc = '0;
        bus8.redirect_valid = 0; bus8.redirect_pc = '0;
        rst8 = 1;
        bus8.trigger = 1;
        tick();
        bus8.trigger = 0;
        bus8.redirect_valid = 1; bus8.redirect_pc = 8'hF8;
        tick();
        bus8.redirect_valid = 0;
        tick();
        n_checks++; if (bus8.pc_out !== 8'hFC) begin n_fail++; $display("FAIL n8_pre_wrap_pc: got %h want fc", bus8.pc_out); end
        n_checks++; if (bus8.pc_plus_inc !== 8'h00) begin n_fail++; $display("FAIL n8_plus_inc_wrap: got %h want 00", bus8.pc_plus_inc); end
        tick();
        n_checks++; if (bus8.pc_out !== 8'h00) begin n_fail++; $display("FAIL n8_wrap_pc: got %h want 00", bus8.pc_out); end
        n_checks++; if (bus8.fetch_count !== 3'd3) begin n_fail++; $display("FAIL n8_count3: got %0d want 3", bus8.fetch_count); end
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (bus8.fetch_count !== 3'd7) begin n_fail++; $display("FAIL n8_count7: got %0d want 7", bus8.fetch_count); end
        tick();
        n_checks++; if (bus8.fetch_count !== 3'd7) begin n_fail++; $display("FAIL n8_count_sat: got %0d want 7", bus8.fetch_count); end
        n_checks++; if (bus8.pc_out !== 8'h14) begin n_fail++; $display("FAIL n8_pc_after_sat: got %h want 14", bus8.pc_out); end
        bus8.redirect_valid = 1; bus8.redirect_pc = 8'h80;
        #1;
        n_checks++; if (bus8.flush !== 1'b1) begin n_fail++; $display("FAIL n8_redir_flush: got %b want 1", bus8.flush); end
        rst8 = 0;
        #1;
        n_checks++; if (bus8.pc_out !== 8'h00) begin n_fail++; $display("FAIL n8_async_rst_pc: got %h want 00", bus8.pc_out); end
        n_checks++; if (bus8.flush !== 1'b0) begin n_fail++; $display("FAIL n8_async_rst_flush: got %b want 0", bus8.flush); end
        n_checks++; if (bus8.fetch_count !== 3'd0) begin n_fail++; $display("FAIL n8_async_rst_count: got %0d want 0", bus8.fetch_count); end
        tick();
        n_checks++; if (bus8.pc_out !== 8'h00) begin n_fail++; $display("FAIL n8_rst_hold_pc: got %h want 00", bus8.pc_out); end
        bus8.redirect_valid = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 0;
        rst8     = 0;
        clear_inputs();
        bus8.trigger = 0; bus8.stall = 0; bus8.halt = 0;
        bus8.trap_valid = 0; bus8.trap_pc = '0;
        bus8.redirect_valid = 0; bus8.redirect_pc = '0;
        test_reset();
        test_start();
        test_stall();
        test_redirect();
        test_misalign();
        test_halt();
        test_narrow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
